// File: rtl/gcd_pkg.sv
// Shared definitions for the subtract-based GCD sequencing controller.
package gcd_pkg;

  localparam int GCD_WIDTH = 4;
  localparam int GCD_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_seq_ctrl_sub.sv
// Shared WIDTH-bit unsigned subtractor; the controller orders the operands
// so the minuend is never smaller than the subtrahend.
module gcd_seq_ctrl_sub #(
  parameter int WIDTH = gcd_pkg::GCD_WIDTH
) (
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] sub_i,
  output logic [WIDTH-1:0] diff_o
);

  // Single subtraction per clock, purely combinational.
  assign diff_o = min_i - sub_i;

endmodule

// File: rtl/gcd_seq_ctrl.sv
// GCD sequencing controller: latches two operands on start, runs Euclid's
// subtraction method through one shared subtractor, then pulses done.
//
// state   | meaning
// IDLE    | waiting for start; result/steps of last job held
// CALC    | one compare/subtract per clock until a terminal case is hit
// FIN     | one-cycle done pulse, then back to IDLE
module gcd_seq_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int CNT_W = GCD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] steps
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] steps_q, steps_d;

  logic             a_gt_b;
  logic [WIDTH-1:0] sub_min, sub_sub, sub_diff;

  // Operand steering: always subtract the smaller register from the larger.
  assign a_gt_b  = a_q > b_q;
  assign sub_min = a_gt_b ? a_q : b_q;
  assign sub_sub = a_gt_b ? b_q : a_q;

  gcd_seq_ctrl_sub #(.WIDTH(WIDTH)) u_sub (
    .min_i  (sub_min),
    .sub_i  (sub_sub),
    .diff_o (sub_diff)
  );

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  // Next-state and datapath update; terminal checks take priority over subtracting.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    steps_d  = steps_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          steps_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (a_q == '0 && b_q == '0) begin
          result_d = '0;
          state_d  = ST_FIN;
        end else if (a_q == '0) begin
          result_d = b_q;
          state_d  = ST_FIN;
        end else if (b_q == '0) begin
          result_d = a_q;
          state_d  = ST_FIN;
        end else if (a_q == b_q) begin
          result_d = a_q;
          state_d  = ST_FIN;
        end else begin
          if (a_gt_b) a_d = sub_diff;
          else        b_d = sub_diff;
          // Saturate rather than wrap so a long job never reports a small count.
          if (steps_q != '1) steps_d = steps_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Self-checking bench for gcd_seq_ctrl: directed table, random jobs against a
// plain-arithmetic GCD model, and hand sequences for start/reset corner cases.
module tb_gcd_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] steps;

  int tests  = 0;
  int failed = 0;

  gcd_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp_r;
    int exp_k;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: Euclid by subtraction, counting subtractions, saturating the count.
  task automatic model(input int a, input int b, output int g, output int k);
    int x = a;
    int y = b;
    k = 0;
    while (!(x == 0 || y == 0 || x == y)) begin
      if (x > y) x = x - y;
      else       y = y - x;
      k++;
    end
    g = (x == 0) ? y : x;
    if (k > (1 << CNT_W) - 1) k = (1 << CNT_W) - 1;
  endtask

  // Wait for done after the accepting edge; checks latency, busy span and outputs.
  task automatic wait_done(input string nm, input int exp_r, input int exp_k);
    int n  = 0;
    int bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    check({nm, " latency"}, n, exp_k + 1);
    check({nm, " busy_cycles"}, bc, exp_k + 1);
    check({nm, " result"}, int'(result), exp_r);
    check({nm, " steps"}, int'(steps), exp_k);
    check({nm, " busy_at_done"}, int'(busy), 0);
    tick();
    check({nm, " done_one_cycle"}, int'(done), 0);
  endtask

  task automatic run_job(input string nm, input int a, input int b, input int exp_r, input int exp_k);
    a_in  = WIDTH'(a);
    b_in  = WIDTH'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    check({nm, " busy_after_start"}, int'(busy), 1);
    check({nm, " steps_cleared"}, int'(steps), 0);
    wait_done(nm, exp_r, exp_k);
  endtask

  initial begin
    int g, k, pulses, prev_r;

    vecs[0] = '{12, 8, 4, 2};
    vecs[1] = '{15, 1, 1, 14};
    vecs[2] = '{6, 6, 6, 0};
    vecs[3] = '{0, 9, 9, 0};
    vecs[4] = '{7, 0, 7, 0};
    vecs[5] = '{0, 0, 0, 0};
    vecs[6] = '{9, 6, 3, 2};

    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset steps", int'(steps), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_job($sformatf("vec%0d(%0d,%0d)", i, vecs[i].a, vecs[i].b),
              vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_k);

    // Result held through IDLE until the next job's start edge.
    prev_r = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle result_held", int'(result), prev_r);
    end

    // start held through CALC and FIN with different operands: ignored until IDLE.
    a_in  = 4'd12;
    b_in  = 4'd8;
    start = 1'b1;
    tick();
    a_in = 4'd3;
    b_in = 4'd5;
    wait_done("hold(12,8)", 4, 2);
    check("hold idle_busy", int'(busy), 0);
    check("hold idle_result", int'(result), 4);
    tick();
    check("hold accept_busy", int'(busy), 1);
    check("hold accept_steps", int'(steps), 0);
    check("hold accept_result_kept", int'(result), 4);
    start = 1'b0;
    model(3, 5, g, k);
    wait_done("hold(3,5)", g, k);

    // Asynchronous reset mid-computation of (15,1).
    a_in  = 4'd15;
    b_in  = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst busy", int'(busy), 0);
    check("arst done", int'(done), 0);
    check("arst result", int'(result), 0);
    check("arst steps", int'(steps), 0);
    #3 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) pulses++;
    end
    check("arst no_done_pulse", pulses, 0);
    run_job("post_rst(9,6)", 9, 6, 3, 2);

    // Random jobs against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      int ra = int'($urandom_range(0, 15));
      int rb = int'($urandom_range(0, 15));
      model(ra, rb, g, k);
      run_job($sformatf("rand(%0d,%0d)", ra, rb), ra, rb, g, k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gcd_seq_ctrl.md
Name: gcd_seq_ctrl

Overview:
Sequencing controller for the subtract-based GCD datapath. It latches two unsigned operands on a start request and computes their GCD by Euclid's subtraction method. One shared WIDTH-bit subtractor performs at most one subtraction per clock. It reports the result, the subtraction count and a one-cycle done pulse. It sits between the top-level input/output logic and the subtractor.

Parameters:
WIDTH, 4, operand/result width in bits (unsigned)
CNT_W, 5, step-counter width; must hold 2^WIDTH-1 without saturating at default

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, sampled with start
b_in  input  WIDTH  operand B, sampled with start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse, high only in FIN
result  output  WIDTH  GCD; valid from done, held until next accepted start
steps  output  CNT_W  number of subtractions performed for last/current job

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, at any time including mid-computation: state=IDLE; a_r=b_r=0; result=0; steps=0; busy=0; done=0. The job is abandoned and there is no done pulse.
- States: IDLE, CALC, FIN. Outputs busy and done are decoded from registered state (Moore).
- IDLE: start=1 at edge E0 latches a_r=a_in, b_r=b_in, clears steps to 0, and moves to CALC. result is held until that edge and is not cleared on start.
- CALC, evaluated each edge, priority order:
  1. a_r==0 and b_r==0 -> result=0, go FIN.
  2. a_r==0 -> result=b_r, go FIN.
  3. b_r==0 -> result=a_r, go FIN.
  4. a_r==b_r -> result=a_r, go FIN.
  5. a_r>b_r -> a_r=a_r-b_r, steps++.
  6. Otherwise -> b_r=b_r-a_r, steps++.
- Subtractor sharing: one subtractor instance only. Minuend/subtrahend muxes select (a_r,b_r) or (b_r,a_r) from the unsigned compare a_r>b_r. The difference is never negative, so no wrap occurs in legal operation.
- steps saturates at 2^CNT_W-1 and never wraps.
- FIN: done=1 for exactly one cycle, then unconditionally to IDLE. start in FIN is ignored.
- start in CALC or FIN is ignored; the operands in flight are unaffected.
- Latency: for k subtractions, done is high in the cycle after edge E0+k+1. Worst case at WIDTH=4 is (15,1), with k=14.
- a_in/b_in changing after E0 has no effect.

Decomposition:
- Shared package gcd_pkg: state encoding constants (ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIN=2'd2), default WIDTH and CNT_W.
- One sub-module: the WIDTH-bit subtractor, instantiated once as the shared datapath unit. The team's existing sub4 is used when WIDTH=4.
- Compare, muxes, FSM and counter stay in gcd_seq_ctrl.

Test Plan:
- (12,8): start at E0 -> a_r goes 4, then b_r goes 4; done pulses one cycle after E0+3; result=4, steps=2, busy high for 3 cycles.
- (15,1) -> result=1, steps=14; done one cycle after E0+15. (6,6) -> result=6, steps=0; done one cycle after E0+1.
- Zero operands: (0,9) -> result=9, steps=0; (7,0) -> result=7; (0,0) -> result=0. Each gives a single done pulse and no hang.
- start pulsed with (3,5) while a (12,8) job is in CALC, and start held high through FIN -> result=4. The new request is not accepted until IDLE; holding start in IDLE starts a new job the next edge.
- rst asserted asynchronously mid-CALC of (15,1) -> all outputs 0 immediately with no done pulse. After release, a new (9,6) job gives result=3, steps=2.
- Back-to-back jobs: result of job 1 stays stable through IDLE and until the start edge of job 2. steps resets to 0 at that edge.
